// File: rtl/pwm_peripheral.sv
// pwm_peripheral -- 16 user outputs: forced low, held high or driven by a shared 8-bit PWM.
// Rev 1.0
`default_nettype none

module pwm_peripheral #(
  parameter int unsigned PRESCALE   = 13,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [15:0] out,
  output logic       period_start
);

  localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [7:0]            pwm_cnt_q, pwm_cnt_d;
  logic [7:0]            duty_sh_q, duty_sh_d;
  logic [15:0]           out_q, out_d;
  logic                  period_start_q, period_start_d;

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic        tick;
  logic        wrap;
  logic        level;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick           = (presc_q == PRESC_MAX);
    wrap           = tick && (pwm_cnt_q == 8'hFF);
    presc_d        = tick ? '0 : presc_q + PRESCALE_W'(1);
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    // Duty is only sampled at the wrap so a period is never cut short or stretched.
    duty_sh_d      = wrap ? pwm_duty_cycle : duty_sh_q;
    // 0xFF is special-cased to stay high through the wrap clock.
    level          = (duty_sh_q == 8'hFF) || (pwm_cnt_q < duty_sh_q);
    out_d          = en_out & (~en_pwm | {16{level}});
    period_start_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      pwm_cnt_q      <= '0;
      duty_sh_q      <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_sh_q      <= duty_sh_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral -- scoreboard bench for pwm_peripheral against a time-based reference model.
// Rev 1.0
`default_nettype none

module tb_pwm_peripheral;

  localparam int P   = 13;
  localparam int PER = 256 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  eo_l, eo_h, ep_l, ep_h, duty;
  logic [15:0] out;
  logic        period_start;

  always #5 clk = ~clk;

  pwm_peripheral #(
    .PRESCALE   (P),
    .PRESCALE_W (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo_l),
    .en_reg_out_15_8 (eo_h),
    .en_reg_pwm_7_0  (ep_l),
    .en_reg_pwm_15_8 (ep_h),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  typedef struct packed {
    logic [15:0] out;
    logic        ps;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: n = clocks since the last reset edge; period k's duty is the
  // request seen at the edge that started period k (period 0 always runs at duty 0).
  int         n = 0;
  logic [7:0] pduty[int];

  logic [15:0] cur_eo = 16'h0000;
  logic [15:0] cur_ep = 16'h0000;
  logic [7:0]  cur_d  = 8'h00;

  task automatic step(input logic r, input logic [15:0] eo, input logic [15:0] ep,
                      input logic [7:0] d);
    int         cnt;
    int         k;
    logic [7:0] dsh;
    logic       lvl;
    exp_t       e;
    @(negedge clk);
    rst = r;
    {eo_h, eo_l} = eo;
    {ep_h, ep_l} = ep;
    duty = d;
    if (r) begin
      e.out = 16'h0000;
      e.ps  = 1'b0;
      n     = 0;
      pduty.delete();
    end else begin
      cnt = (n / P) % 256;
      k   = n / PER;
      dsh = (k == 0) ? 8'h00 : pduty[k];
      lvl = (dsh == 8'hFF) ? 1'b1 : (cnt < int'(dsh));
      for (int i = 0; i < 16; i++)
        e.out[i] = eo[i] ? (ep[i] ? lvl : 1'b1) : 1'b0;
      n++;
      e.ps = ((n % PER) == 0);
      if (e.ps) pduty[n / PER] = d;
    end
    sbq.push_back(e);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, cur_eo, cur_ep, cur_d);
  endtask

  task automatic run_to_phase(input int ph);
    for (int c = 0; c < 2 * PER; c++) begin
      if ((n % PER) == ph) break;
      step(1'b0, cur_eo, cur_ep, cur_d);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checks++;
      if (out !== mon_e.out) begin
        errors++;
        $display("FAIL out n=%0d got %h expected %h", n, out, mon_e.out);
      end
      checks++;
      if (period_start !== mon_e.ps) begin
        errors++;
        $display("FAIL period_start n=%0d got %b expected %b", n, period_start, mon_e.ps);
      end
    end
  end

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog expired got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {eo_h, eo_l, ep_h, ep_l, duty} = '0;

    // Reset with every config byte at 0xFF, then the first period stays low.
    repeat (5) step(1'b1, 16'hFFFF, 16'hFFFF, 8'hFF);
    cur_eo = 16'hFFFF; cur_ep = 16'hFFFF; cur_d = 8'hFF;
    run(PER + 20);

    // Static enables, no PWM.
    cur_eo = 16'hFFFF; cur_ep = 16'h0000; cur_d = 8'h00;
    run(3);
    cur_eo = 16'h00F0;
    run(3);

    // 50% duty on out[0]; out[8] selects PWM but is disabled.
    cur_eo = 16'h0001; cur_ep = 16'h0101; cur_d = 8'h80;
    run_to_phase(0);
    run(2 * PER + 100);

    // Duty extremes across several wraps.
    cur_d = 8'h00;
    run_to_phase(0);
    run(PER + 10);
    cur_d = 8'hFF;
    run_to_phase(0);
    run(3 * PER + 10);

    // Mid-period duty change only lands at the next wrap.
    cur_d = 8'h40;
    run_to_phase(1);
    run_to_phase(200);
    cur_d = 8'hC0;
    run_to_phase(1);
    run_to_phase(0);

    // Reset while out[0] is high.
    run_to_phase(300);
    step(1'b1, cur_eo, cur_ep, cur_d);
    run(PER + 50);

    // Random segments of enables, duty and occasional reset.
    for (int s = 0; s < 10; s++) begin
      cur_eo = 16'($urandom);
      cur_ep = 16'($urandom);
      cur_d  = 8'($urandom);
      if (($urandom % 4) == 0) step(1'b1, cur_eo, cur_ep, cur_d);
      run($urandom_range(50, 1500));
    end

    repeat (3) @(posedge clk);
    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
